// File: rtl/cell_share_pkg.sv
// Shared types and constants for the cell_share_arbiter slice.
//   state_e     : arbiter FSM states
//   SEL_*       : bit positions inside a 4-bit select slice {A1,B1,A0,B0}
//   D00..D11    : bit positions inside a 4-bit truth-table slice {D11,D10,D01,D00}
// The shared cell evaluates tt[{A1|B1, A0&B0}] and registers it.
package cell_share_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam int unsigned SEL_A1 = 3;
  localparam int unsigned SEL_B1 = 2;
  localparam int unsigned SEL_A0 = 1;
  localparam int unsigned SEL_B0 = 0;

  localparam int unsigned D00 = 0;
  localparam int unsigned D01 = 1;
  localparam int unsigned D10 = 2;
  localparam int unsigned D11 = 3;

endpackage

// File: rtl/cell_share_arbiter_if.sv
// Bundle of requester-side and cell-side signals of cell_share_arbiter.
//   req/tt/sel      : per-requester request level, truth table, selects
//   gnt             : one-hot grant back to requesters
//   cell_d/cell_sel : registered inputs to the shared cell
//   cell_clr/cell_q : shared flop clear and registered output
//   rsp_*           : one-cycle tagged response
// master: the arbiter side; slave: the requester/cell environment.
interface cell_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] tt;
  logic [4*NREQ-1:0] sel;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        cell_d;
  logic [3:0]        cell_sel;
  logic              cell_clr;
  logic              cell_q;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_data;

  modport master (
    input  req, tt, sel, cell_q,
    output gnt, cell_d, cell_sel, cell_clr, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    output req, tt, sel, cell_q,
    input  gnt, cell_d, cell_sel, cell_clr, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/cell_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   eligible : candidate requesters
//   pointer  : last granted index; search starts at pointer+1 and wraps
//   any      : at least one candidate
//   winner   : first eligible index found (0 when none)
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  pointer,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  logic [IDW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    // i = NREQ lands back on pointer itself, so it has lowest priority
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IDW'((32'(pointer) + i) % NREQ);
      if (!any && eligible[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/cell_share_arbiter.sv
// Round-robin sequencer time-sharing one external registered 4:1 logic cell.
//   clk : rising-edge clock
//   clr : asynchronous active-low reset (also clears the shared cell flop)
//   bus : cell_share_arbiter_if.master -- requests, grants, cell drive, responses
// Each transaction: IDLE (arbitrate) -> DRIVE (cell inputs stable, flop samples)
// -> CAPTURE (cell_q valid) -> IDLE with a one-cycle tagged response.
module cell_share_arbiter
  import cell_share_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input logic                       clk,
  input logic                       clr,
  cell_share_arbiter_if.master      bus
);

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic [3:0]      cell_d_q;
  logic [3:0]      cell_sel_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_data_q;

  logic [NREQ-1:0] served_mask;
  logic [NREQ-1:0] eligible;
  logic            any;
  logic [IDW-1:0]  winner;

  // The requester being answered this cycle still has req high; hide it so
  // it cannot be re-granted before it has seen its response.
  assign served_mask = rsp_valid_q ? (NREQ'(1) << rsp_id_q) : '0;
  assign eligible    = bus.req & ~served_mask;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .eligible (eligible),
    .pointer  (ptr_q),
    .any      (any),
    .winner   (winner)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      gnt_q       <= '0;
      cell_d_q    <= '0;
      cell_sel_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any) begin
            gnt_q      <= NREQ'(1) << winner;
            cell_d_q   <= bus.tt[{winner, 2'b00} +: 4];
            cell_sel_q <= bus.sel[{winner, 2'b00} +: 4];
            ptr_q      <= winner;
            state_q    <= DRIVE;
          end
        end
        DRIVE: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          rsp_data_q  <= bus.cell_q;
          rsp_id_q    <= ptr_q;
          rsp_valid_q <= 1'b1;
          gnt_q       <= '0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.cell_d    = cell_d_q;
  assign bus.cell_sel  = cell_sel_q;
  assign bus.cell_clr  = ~clr;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cell_share_arbiter.sv
// Directed bench for cell_share_arbiter with a behavioural model of the
// shared cell (4:1 mux into a clearable flop).
module tb_cell_share_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  cell_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  cell_share_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared cell: q <= d[{A1|B1, A0&B0}], async clear high.
  logic cell_q_m;
  always @(posedge clk or posedge bus.cell_clr) begin
    if (bus.cell_clr) cell_q_m <= 1'b0;
    else cell_q_m <= bus.cell_d[{bus.cell_sel[3] | bus.cell_sel[2],
                                 bus.cell_sel[1] & bus.cell_sel[0]}];
  end
  assign bus.cell_q = cell_q_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] id, input logic [31:0] data);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, " rsp_id"}, 32'(bus.rsp_id), id);
    check({tag, " rsp_data"}, 32'(bus.rsp_data), data);
    check({tag, " gnt low"}, 32'(bus.gnt), 32'd0);
  endtask

  task automatic do_reset();
    clr = 1'b0;
    tick();
    tick();
    clr = 1'b1;
  endtask

  initial begin
    bus.req = '0;
    bus.tt  = '0;
    bus.sel = '0;

    // Reset state
    #2;
    check("rst gnt", 32'(bus.gnt), 32'd0);
    check("rst cell_d", 32'(bus.cell_d), 32'd0);
    check("rst cell_sel", 32'(bus.cell_sel), 32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst cell_clr", 32'(bus.cell_clr), 32'd1);
    tick();
    tick();
    clr = 1'b1;
    #1;
    check("run cell_clr", 32'(bus.cell_clr), 32'd0);

    // 1: single transaction, tt0=0100 sel0=1000 -> index 2 -> 1
    bus.req = 4'b0001;
    bus.tt  = 16'h0004;
    bus.sel = 16'h0008;
    tick();
    check("t1 gnt drive", 32'(bus.gnt), 32'h1);
    check("t1 cell_d", 32'(bus.cell_d), 32'h4);
    check("t1 cell_sel", 32'(bus.cell_sel), 32'h8);
    check("t1 no early rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("t1 gnt capture", 32'(bus.gnt), 32'h1);
    tick();
    check_rsp("t1", 32'd0, 32'd1);
    bus.req = '0;
    tick();
    check("t1 rsp one cycle", 32'(bus.rsp_valid), 32'd0);
    check("t1 idle gnt", 32'(bus.gnt), 32'd0);

    // 2: all requesting, round-robin 0,1,2,3,0; tt=1000 sel=1111 -> index 3 -> 1
    do_reset();
    bus.req = 4'b1111;
    bus.tt  = 16'h8888;
    bus.sel = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2 gnt", 32'(bus.gnt), 32'(1) << (k % 4));
      tick();
      tick();
      check_rsp("t2", 32'(k % 4), 32'd1);
    end
    bus.req = '0;
    tick();
    check("t2 no grant", 32'(bus.gnt), 32'd0);
    check("t2 rsp cleared", 32'(bus.rsp_valid), 32'd0);

    // 3: lone requester 2 re-granted every 4 cycles; tt2=0001 sel2=0000 -> 1
    bus.req = 4'b0100;
    bus.tt  = 16'h0100;
    bus.sel = 16'h0000;
    tick();
    check("t3 gnt first", 32'(bus.gnt), 32'h4);
    for (int r = 0; r < 2; r++) begin
      tick();
      tick();
      check_rsp("t3", 32'd2, 32'd1);
      tick();
      check("t3 masked gnt", 32'(bus.gnt), 32'd0);
      check("t3 masked rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
      check("t3 regrant", 32'(bus.gnt), 32'h4);
    end
    bus.req = '0;
    tick();
    tick();
    check_rsp("t3 last", 32'd2, 32'd1);
    tick();

    // 4: tt1 changes during DRIVE; grant-time value must be used
    bus.req = 4'b0010;
    bus.tt  = 16'h0010;
    bus.sel = 16'h0000;
    tick();
    check("t4 gnt", 32'(bus.gnt), 32'h2);
    bus.tt = 16'h0000;
    tick();
    check("t4 cell_d held", 32'(bus.cell_d), 32'h1);
    tick();
    check_rsp("t4", 32'd1, 32'd1);
    bus.req = '0;
    tick();

    // 5: reset during CAPTURE of requester 3
    bus.req = 4'b1000;
    bus.tt  = 16'hF000;
    bus.sel = 16'h0000;
    tick();
    check("t5 gnt", 32'(bus.gnt), 32'h8);
    tick();
    clr = 1'b0;
    #1;
    check("t5 abort gnt", 32'(bus.gnt), 32'd0);
    check("t5 abort cell_clr", 32'(bus.cell_clr), 32'd1);
    check("t5 abort rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("t5 held rsp", 32'(bus.rsp_valid), 32'd0);
    check("t5 held gnt", 32'(bus.gnt), 32'd0);
    bus.req = 4'b1001;
    bus.tt  = 16'hF00F;
    clr     = 1'b1;
    tick();
    check("t5 id0 first", 32'(bus.gnt), 32'h1);
    tick();
    tick();
    check_rsp("t5 id0", 32'd0, 32'd1);
    tick();
    check("t5 then id3", 32'(bus.gnt), 32'h8);
    tick();
    tick();
    check_rsp("t5 id3", 32'd3, 32'd1);
    bus.req = '0;
    tick();

    // 6: requester 1 drops req in DRIVE; response still issued, then ID 2
    bus.req = 4'b0110;
    bus.tt  = 16'h0010;
    bus.sel = 16'h0000;
    tick();
    check("t6 gnt1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0100;
    tick();
    tick();
    check_rsp("t6 id1", 32'd1, 32'd1);
    tick();
    check("t6 gnt2", 32'(bus.gnt), 32'h4);
    tick();
    tick();
    check_rsp("t6 id2", 32'd2, 32'd0);
    bus.req = '0;
    tick();
    check("t6 end rsp", 32'(bus.rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
